// File: rtl/fb_sequence_loader.sv
// rtl/fb_sequence_loader.sv - loads NUM_FRAMES source frames into the frame buffer, then captures one masked output frame
// Optional: define FB_SEQ_CAPTURE_CRC_EN to add cap_crc (CRC-16-CCITT over captured words).
module fb_sequence_loader #(
    parameter int FRAME_WIDTH    = 320,
    parameter int FRAME_HEIGHT   = 240,
    parameter int PIXEL_BITS     = 16,
    parameter int ADDR_BITS      = 17,
    parameter int NUM_FRAMES     = 2,
    parameter int CAPTURE_PIXELS = 307200
) (
    input  logic                  clk_25MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [PIXEL_BITS-1:0] src_data,
    output logic [3:0]            frame_idx,
    output logic                  wren,
    output logic [ADDR_BITS-1:0]  wraddress,
    output logic [PIXEL_BITS-1:0] wrdata,
    input  logic                  vsync,
    input  logic                  pixel_valid,
    input  logic                  fg_mask,
    input  logic [PIXEL_BITS-1:0] pixel_rgb565,
    output logic                  cap_valid,
    output logic [PIXEL_BITS-1:0] cap_data,
    output logic [31:0]           cap_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef FB_SEQ_CAPTURE_CRC_EN
    ,
    output logic [15:0]           cap_crc
`endif
);

    localparam int IDX_W        = ADDR_BITS + 1;
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [IDX_W-1:0] FP_COUNT   = IDX_W'(FRAME_PIXELS);
    localparam logic [IDX_W-1:0] FP_LAST    = IDX_W'(FRAME_PIXELS - 1);
    localparam logic [3:0]       LAST_FRAME = 4'(NUM_FRAMES - 1);
    localparam logic [31:0]      CAP_TOTAL  = 32'(CAPTURE_PIXELS);
    localparam logic [31:0]      CAP_LAST   = 32'(CAPTURE_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_VSYNC,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  vsync_prev;
    logic                  vsync_rise;
    logic                  src_accept;
    logic [PIXEL_BITS-1:0] masked_pixel;

    assign vsync_rise   = vsync & ~vsync_prev;
    assign src_ready    = (state == S_LOAD) && (idx < FP_COUNT);
    assign src_accept   = src_valid & src_ready;
    assign masked_pixel = fg_mask ? pixel_rgb565 : '0;

`ifdef FB_SEQ_CAPTURE_CRC_EN
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [PIXEL_BITS-1:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = PIXEL_BITS - 1; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            vsync_prev <= 1'b1;   // vsync high through reset must not look like a rise
            frame_idx  <= '0;
            wren       <= 1'b0;
            wraddress  <= '0;
            wrdata     <= '0;
            cap_valid  <= 1'b0;
            cap_data   <= '0;
            cap_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef FB_SEQ_CAPTURE_CRC_EN
            cap_crc    <= '0;
`endif
        end else begin
            vsync_prev <= vsync;
            wren       <= 1'b0;
            cap_valid  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        idx       <= '0;
                        frame_idx <= '0;
                        err       <= 1'b0;
                        cap_count <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (src_accept) begin
                        wren      <= 1'b1;
                        wraddress <= idx[ADDR_BITS-1:0];
                        wrdata    <= src_data;
                        idx       <= idx + 1'b1;
                        if (idx == FP_LAST)
                            state <= (frame_idx < LAST_FRAME) ? S_WAIT_VSYNC : S_ARM;
                    end
                end
                S_WAIT_VSYNC: begin
                    if (vsync_rise) begin
                        frame_idx <= frame_idx + 1'b1;
                        idx       <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_ARM: begin
                    if (vsync_rise) begin
                        state     <= S_CAPTURE;
                        cap_count <= '0;
`ifdef FB_SEQ_CAPTURE_CRC_EN
                        cap_crc   <= 16'hFFFF;
`endif
                    end
                end
                S_CAPTURE: begin
                    if (pixel_valid) begin
                        cap_valid <= 1'b1;
                        cap_data  <= masked_pixel;
                        if (cap_count != CAP_TOTAL)
                            cap_count <= cap_count + 1'b1;
`ifdef FB_SEQ_CAPTURE_CRC_EN
                        cap_crc   <= crc16_word(cap_crc, masked_pixel);
`endif
                    end
                    // Completion wins over a vsync rise landing on the final beat.
                    if (pixel_valid && cap_count == CAP_LAST) begin
                        state <= S_DONE;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (vsync_rise) begin
                        state <= S_DONE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_sequence_loader.sv
// tb/tb_fb_sequence_loader.sv - directed bench for fb_sequence_loader with a 4x2 frame, two frames, 8-pixel capture
module tb_fb_sequence_loader;

    logic        clk_25MHz = 1'b0;
    logic        reset, start, src_valid, vsync, pixel_valid, fg_mask;
    logic [15:0] src_data, pixel_rgb565;
    logic        src_ready, wren, cap_valid, busy, done, err;
    logic [3:0]  frame_idx;
    logic [2:0]  wraddress;
    logic [15:0] wrdata, cap_data;
    logic [31:0] cap_count;

    int errors = 0;
    int checks = 0;

    fb_sequence_loader #(
        .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .PIXEL_BITS(16), .ADDR_BITS(3),
        .NUM_FRAMES(2), .CAPTURE_PIXELS(8)
    ) dut (
        .clk_25MHz(clk_25MHz), .reset(reset), .start(start),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .frame_idx(frame_idx), .wren(wren), .wraddress(wraddress), .wrdata(wrdata),
        .vsync(vsync), .pixel_valid(pixel_valid), .fg_mask(fg_mask),
        .pixel_rgb565(pixel_rgb565), .cap_valid(cap_valid), .cap_data(cap_data),
        .cap_count(cap_count), .busy(busy), .done(done), .err(err)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    // Feeds base+n pixels and checks every write lands at address n with frame index fidx.
    task automatic load_frame(input logic [15:0] base, input bit toggle,
                              input logic [3:0] fidx, input string tag);
        int  nwr;
        int  sent;
        bit  acc;
        nwr  = 0;
        sent = 0;
        for (int cyc = 0; cyc < 40 && nwr < 8; cyc++) begin
            src_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            src_data  = base + 16'(sent);
            acc       = src_valid && src_ready;
            tick();
            if (acc) sent++;
            if (wren) begin
                check({tag, "_addr"}, 32'(wraddress), 32'(nwr));
                check({tag, "_data"}, 32'(wrdata), 32'(base + 16'(nwr)));
                check({tag, "_fidx"}, 32'(frame_idx), 32'(fidx));
                nwr++;
            end
        end
        check({tag, "_nwrites"}, 32'(nwr), 32'd8);
    endtask

    task automatic quiet(input int n, input string tag);
        int bad;
        bad = 0;
        repeat (n) begin
            tick();
            if (wren || src_ready) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b1; vsync = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
        pixel_valid = 1'b0; fg_mask = 1'b0; pixel_rgb565 = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        reset = 1'b0;

        bad = 0;
        repeat (10) begin
            tick();
            if (wren || busy || done || err || cap_valid || src_ready) bad++;
        end
        check("idle_vsync_high", 32'(bad), 32'd0);
        check("idle_frame_idx", 32'(frame_idx), 32'd0);
        check("idle_cap_count", cap_count, 32'd0);
        vsync = 1'b0;
        tick();

        // Sequence 1: src_valid held high, full capture
        start = 1'b1; tick(); start = 1'b0;
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_frame_idx", 32'(frame_idx), 32'd0);
        load_frame(16'h1000, 1'b0, 4'd0, "s1f0");
        quiet(4, "s1_wait_quiet");
        start = 1'b1; tick(); start = 1'b0;
        check("s1_start_ignored_busy", 32'(busy), 32'd1);
        quiet(2, "s1_start_ignored");
        vsync = 1'b1; tick(); vsync = 1'b0;
        check("s1_f1_idx", 32'(frame_idx), 32'd1);
        check("s1_f1_ready", 32'(src_ready), 32'd1);
        load_frame(16'h2000, 1'b0, 4'd1, "s1f1");
        src_valid = 1'b0;
        quiet(2, "s1_arm_quiet");
        pixel_valid = 1'b1; fg_mask = 1'b1; pixel_rgb565 = 16'hF800;
        tick();
        pixel_valid = 1'b0;
        check("s1_arm_no_cap", 32'(cap_valid), 32'd0);
        vsync = 1'b1; tick(); vsync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1'b1; fg_mask = (i % 2 == 0); pixel_rgb565 = 16'hF800;
            tick();
            check("s1_cap_valid", 32'(cap_valid), 32'd1);
            check("s1_cap_data", 32'(cap_data), (i % 2 == 0) ? 32'h0000F800 : 32'h0);
        end
        pixel_valid = 1'b0;
        check("s1_cap_count", cap_count, 32'd8);
        check("s1_done", 32'(done), 32'd1);
        check("s1_err", 32'(err), 32'd0);
        check("s1_busy_done", 32'(busy), 32'd0);
        tick();
        check("s1_cap_idle", 32'(cap_valid), 32'd0);
        check("s1_done_hold", 32'(done), 32'd1);

        // Sequence 2: toggling src_valid, capture cut short by vsync
        start = 1'b1; tick(); start = 1'b0;
        check("s2_done_clr", 32'(done), 32'd0);
        check("s2_count_clr", cap_count, 32'd0);
        check("s2_busy", 32'(busy), 32'd1);
        load_frame(16'h1000, 1'b1, 4'd0, "s2f0");
        quiet(3, "s2_wait_quiet");
        vsync = 1'b1; tick(); vsync = 1'b0;
        load_frame(16'h2000, 1'b1, 4'd1, "s2f1");
        src_valid = 1'b0;
        vsync = 1'b1; tick(); vsync = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1; fg_mask = 1'b1; pixel_rgb565 = 16'h0AB0 + 16'(i);
            if (i == 4) vsync = 1'b1;
            tick();
            check("s2_cap_data", 32'(cap_data), 32'h0AB0 + 32'(i));
        end
        pixel_valid = 1'b0; vsync = 1'b0;
        check("s2_done", 32'(done), 32'd1);
        check("s2_err", 32'(err), 32'd1);
        check("s2_cap_count", cap_count, 32'd5);
        check("s2_busy", 32'(busy), 32'd0);

        // Sequence 3: reset mid-load, then reload from address 0
        tick();
        start = 1'b1; tick(); start = 1'b0;
        src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data = 16'h5000 + 16'(i);
            tick();
        end
        check("s3_pre_wren", 32'(wren), 32'd1);
        check("s3_pre_addr", 32'(wraddress), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        src_valid = 1'b0;
        check("s3_rst_wren", 32'(wren), 32'd0);
        check("s3_rst_busy", 32'(busy), 32'd0);
        check("s3_rst_ready", 32'(src_ready), 32'd0);
        tick();
        check("s3_idle_wren", 32'(wren), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("s3_frame_idx", 32'(frame_idx), 32'd0);
        load_frame(16'h3000, 1'b0, 4'd0, "s3f0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
